// File: rtl/time_tmr_pkg.sv
// Shared types and constants for the time-redundant (TMR) dispatch logic.
package time_tmr_pkg;

    localparam int unsigned NumReplicas = 3;

    typedef logic [7:0] credit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REP1 = 2'd1,
        REP2 = 2'd2
    } dispatch_state_e;

endpackage

// File: rtl/time_tmr_credit_cnt.sv
// Per-group credit counter: take consumes a credit, give returns one, saturating at MaxCredit.
module time_tmr_credit_cnt
    import time_tmr_pkg::*;
#(
    parameter credit_t MaxCredit = credit_t'(3)
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    take_i,
    input  logic    give_i,
    output credit_t count_o,
    output logic    max_o
);

    credit_t count_q, count_d;

    // A simultaneous take and give cancel; a give while full is dropped.
    always_comb begin
        count_d = count_q;
        if (take_i && !give_i) begin
            count_d = count_q - credit_t'(1);
        end else if (give_i && !take_i && (count_q < MaxCredit)) begin
            count_d = count_q + credit_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= MaxCredit;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign max_o   = (count_q == MaxCredit);

endmodule

// File: rtl/time_tmr_opgroup_dispatch.sv
// Credit-based dispatcher steering items (or whole replica triplets) to operation groups.
// Optional lock timeout is enabled by defining TIME_TMR_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no triplet open; new item needs 3 credits (enable_i=1) or 1 credit (enable_i=0)
// REP1  | first replica accepted; only the same group/ID may follow
// REP2  | second replica accepted; the next matching item closes the triplet
module time_tmr_opgroup_dispatch
    import time_tmr_pkg::*;
#(
    parameter int unsigned                   NumOpgroups    = 3,
    parameter logic [NumOpgroups-1:0][7:0]   OpgroupCredits = {8'd4, 8'd3, 8'd3},
    parameter int unsigned                   IDSize         = 9,
    parameter type                           DataType       = logic [7:0],
    parameter int unsigned                   LockTimeout    = 60,
    localparam int unsigned                  OpW            = (NumOpgroups > 1) ? $clog2(NumOpgroups) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  DataType                data_i,
    input  logic [IDSize-1:0]      id_i,
    input  logic [OpW-1:0]         operation_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [NumOpgroups-1:0] opgrp_valid_o,
    input  logic [NumOpgroups-1:0] opgrp_ready_i,
    output DataType                opgrp_data_o,
    output logic [IDSize-1:0]      opgrp_id_o,
    input  logic [NumOpgroups-1:0] opgrp_retire_i,
    output logic                   busy_o,
    output logic                   fault_o
);

    dispatch_state_e state_q, state_d;
    logic [OpW-1:0]    grp_q, grp_d;
    logic [IDSize-1:0] id_q, id_d;

    credit_t                credit [NumOpgroups];
    logic [NumOpgroups-1:0] credit_full;
    logic [NumOpgroups-1:0] take;

    credit_t sel_credit;
    credit_t need_credit;
    logic    sel_ready;
    logic    op_hit;
    logic    lock_match;
    logic    allow;
    logic    handshake;
    logic    tmo_hit;

    for (genvar g = 0; g < NumOpgroups; g++) begin : g_credit
        time_tmr_credit_cnt #(
            .MaxCredit (OpgroupCredits[g])
        ) u_credit_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .take_i  (take[g]),
            .give_i  (opgrp_retire_i[g]),
            .count_o (credit[g]),
            .max_o   (credit_full[g])
        );
    end

    // Operation codes beyond the last group select nothing and are never accepted.
    always_comb begin
        op_hit     = 1'b0;
        sel_credit = '0;
        sel_ready  = 1'b0;
        for (int g = 0; g < NumOpgroups; g++) begin
            if (operation_i == OpW'(g)) begin
                op_hit     = 1'b1;
                sel_credit = credit[g];
                sel_ready  = opgrp_ready_i[g];
            end
        end
    end

    assign lock_match  = (operation_i == grp_q) && (id_i == id_q);
    assign need_credit = enable_i ? credit_t'(NumReplicas) : credit_t'(1);

    always_comb begin
        allow = 1'b0;
        if (state_q == IDLE) begin
            allow = op_hit && (sel_credit >= need_credit);
        end else begin
            allow = lock_match;
        end
    end

    assign ready_o   = sel_ready & allow;
    assign handshake = valid_i & ready_o;

    always_comb begin
        opgrp_valid_o = '0;
        take          = '0;
        for (int g = 0; g < NumOpgroups; g++) begin
            opgrp_valid_o[g] = valid_i & allow & (operation_i == OpW'(g));
            take[g]          = handshake & (operation_i == OpW'(g));
        end
    end

    assign opgrp_data_o = data_i;
    assign opgrp_id_o   = id_i;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        id_d    = id_q;
        fault_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (handshake && enable_i) begin
                    state_d = REP1;
                    grp_d   = operation_i;
                    id_d    = id_i;
                end
            end
            REP1, REP2: begin
                // A foreign item breaks the triplet; it is retried from IDLE next cycle.
                if (valid_i && !lock_match) begin
                    fault_o = 1'b1;
                    state_d = IDLE;
                end else if (handshake) begin
                    state_d = (state_q == REP1) ? REP2 : IDLE;
                end else if (tmo_hit) begin
                    fault_o = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TIME_TMR_DISPATCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(LockTimeout + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // tmo_q counts completed waiting cycles; the LockTimeout-th waiting cycle faults.
    assign tmo_hit = (state_q != IDLE) && !handshake && (tmo_q == TmoW'(LockTimeout - 1));

    always_comb begin
        tmo_d = tmo_q + TmoW'(1);
        if ((state_d == IDLE) || handshake) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grp_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            id_q    <= id_d;
        end
    end

    assign busy_o = (state_q != IDLE) | ~(&credit_full);

endmodule

// File: tb/tb_time_tmr_opgroup_dispatch.sv
// Self-checking bench for time_tmr_opgroup_dispatch: per-cycle model comparison plus directed scenarios.
module tb_time_tmr_opgroup_dispatch;

    localparam int NG  = 3;
    localparam logic [NG-1:0][7:0] CAPS = {8'd4, 8'd3, 8'd3};
    localparam int TMO = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data = '0;
    logic [8:0] id = '0;
    logic [1:0] op = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [2:0] gvalid;
    logic [2:0] gready = '0;
    logic [7:0] odata;
    logic [8:0] oid;
    logic [2:0] retire = '0;
    logic       busy;
    logic       fault;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Model: credits per group, replicas accepted in the open triplet, its group/ID, idle wait cycles.
    int m_cr [NG];
    int m_reps;
    int m_grp;
    int m_id;
    int m_wait;

    always #5 clk = ~clk;

    time_tmr_opgroup_dispatch dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (en),
        .data_i         (data),
        .id_i           (id),
        .operation_i    (op),
        .valid_i        (valid),
        .ready_o        (ready),
        .opgrp_valid_o  (gvalid),
        .opgrp_ready_i  (gready),
        .opgrp_data_o   (odata),
        .opgrp_id_o     (oid),
        .opgrp_retire_i (retire),
        .busy_o         (busy),
        .fault_o        (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int g = 0; g < NG; g++) m_cr[g] = int'(CAPS[g]);
        m_reps = 0;
        m_grp  = 0;
        m_id   = 0;
        m_wait = 0;
    endtask

    always @(negedge clk) begin : cmp
        int         opi;
        bit         inr, hit, allow, hs, mism, tmo, exp_ready, exp_fault, exp_busy;
        logic [2:0] exp_gv;
        if (!rst_n) begin
            m_reset();
            check("rst_busy", busy, 0);
            check("rst_fault", fault, 0);
            check("rst_gvalid", gvalid, 0);
        end else begin
            opi   = int'(op);
            inr   = opi < NG;
            hit   = (m_reps != 0) && (opi == m_grp) && (int'(id) == m_id);
            if (m_reps == 0) allow = inr && (m_cr[opi] >= (en ? 3 : 1));
            else             allow = hit;
            exp_ready = allow && inr && gready[opi];
            exp_gv    = (valid && allow && inr) ? (3'b001 << opi) : 3'b000;
            hs        = valid && exp_ready;
            mism      = (m_reps != 0) && valid && !hit;
            tmo       = 1'b0;
`ifdef TIME_TMR_DISPATCH_TIMEOUT_EN
            tmo       = (m_reps != 0) && !mism && !hs && (m_wait + 1 == TMO);
`endif
            exp_fault = mism || tmo;
            exp_busy  = (m_reps != 0);
            for (int g = 0; g < NG; g++) if (m_cr[g] != int'(CAPS[g])) exp_busy = 1'b1;

            check("ready", ready, exp_ready);
            check("gvalid", gvalid, exp_gv);
            check("fault", fault, exp_fault);
            check("busy", busy, exp_busy);
            check("data", odata, data);
            check("id", oid, id);

            for (int g = 0; g < NG; g++) begin
                bit tk;
                tk = hs && (opi == g);
                if (tk && !retire[g]) m_cr[g]--;
                else if (!tk && retire[g] && m_cr[g] < int'(CAPS[g])) m_cr[g]++;
            end
            if (m_reps == 0) begin
                if (hs && en) begin
                    m_reps = 1; m_grp = opi; m_id = int'(id); m_wait = 0;
                end
            end else if (mism || tmo) begin
                m_reps = 0;
            end else if (hs) begin
                m_reps++;
                m_wait = 0;
                if (m_reps == 3) m_reps = 0;
            end else begin
                m_wait++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill();
        valid  = 1'b0;
        retire = 3'b111;
        repeat (5) tick();
        retire = 3'b000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("init_ready", ready, 0);
        check("init_gvalid", gvalid, 0);
        check("init_busy", busy, 0);
        check("init_fault", fault, 0);
        rst_n  = 1'b1;
        gready = 3'b111;
        tick();

        // Credit limit without redundancy: group 2 holds 4 items.
        en = 1'b0; valid = 1'b1; op = 2'd2; id = 9'h001; data = 8'h3c;
        for (int i = 0; i < 4; i++) begin
            #1 check("cred_accept", ready, 1);
            tick();
        end
        #1 check("cred_stall5", ready, 0);
        retire = 3'b100;
        tick();
        retire = 3'b000;
        #1 check("cred_after_retire", ready, 1);
        tick();
        refill();

        // Triplet to group 1 drains its 3 credits, then the FSM is idle again.
        en = 1'b1; valid = 1'b1; op = 2'd1; id = 9'h005;
        for (int i = 0; i < 3; i++) begin
            #1 check("trip_ready", ready, 1);
            check("trip_gvalid", gvalid, 3'b010);
            tick();
        end
        #1 check("trip_nocredit", ready, 0);
        check("trip_busy", busy, 1);
        refill();
        check("trip_refilled", busy, 0);

        // Group 2 at credit 2 cannot start a triplet until one retire.
        en = 1'b0; valid = 1'b1; op = 2'd2; id = 9'h003;
        tick(); tick();
        en = 1'b1; id = 9'h007;
        #1 check("short_stall", ready, 0);
        retire = 3'b100;
        tick();
        retire = 3'b000;
        #1 check("short_accept", ready, 1);
        tick(); tick(); tick();
        refill();

        // Broken triplet; retires alongside replicas keep group 0 credit unchanged.
        en = 1'b1; valid = 1'b1; op = 2'd0; id = 9'h005; retire = 3'b001;
        #1 check("brk_rep1", ready, 1);
        tick();
        check("brk_rep2", ready, 1);
        tick();
        retire = 3'b000; id = 9'h006;
        #1 check("brk_noaccept", ready, 0);
        check("brk_fault", fault, 1);
        tick();
        check("brk_fault_once", fault, 0);
        check("brk_reaccept", ready, 1);
        check("brk_gvalid", gvalid, 3'b001);
        tick(); tick(); tick();
        refill();

        // Reset during REP2 restores idle state and full credits.
        en = 1'b1; valid = 1'b1; op = 2'd1; id = 9'h009;
        tick(); tick();
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rstmid_busy", busy, 0);
        check("rstmid_fault", fault, 0);
        tick();
        rst_n = 1'b1;
        valid = 1'b1; id = 9'h00a;
        #1 check("rstmid_reaccept", ready, 1);
        tick(); tick(); tick();
        refill();

`ifdef TIME_TMR_DISPATCH_TIMEOUT_EN
        en = 1'b1; valid = 1'b1; op = 2'd2; id = 9'h011;
        tick();
        valid = 1'b0;
        for (int k = 1; k < TMO; k++) tick();
        #1 check("tmo_fault", fault, 1);
        tick();
        valid = 1'b1; id = 9'h012;
        #1 check("tmo_idle_accept", ready, 1);
        tick(); tick(); tick();
        refill();
`endif

        // Randomized traffic; IDs/ops are sticky so triplets often complete.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) >= 75) begin
                op = 2'($urandom_range(3));
                id = 9'($urandom_range(7));
            end
            valid  = ($urandom_range(99) < 75);
            en     = ($urandom_range(99) < 85);
            data   = 8'($urandom);
            for (int g = 0; g < NG; g++) begin
                gready[g] = ($urandom_range(99) < 85);
                retire[g] = ($urandom_range(99) < 30);
            end
            if ($urandom_range(999) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        valid = 1'b0;
        refill();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
